// File: rtl/kgp_pkg.sv
// kgp_pkg: generate/propagate pair and prefix operator shared by the Kogge-Stone adder and subtractor
package kgp_pkg;
  localparam int KGP_WIDTH = 16;
  localparam int KGP_LEVELS = $clog2(KGP_WIDTH);
  typedef struct packed {
    logic g;
    logic p;
  } kgp_t;
  function automatic kgp_t prefix_op(input kgp_t hi, input kgp_t lo);
    kgp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction
endpackage

// File: rtl/pipelined_ks_subtractor_if.sv
// pipelined_ks_subtractor_if: operand/result valid-ready bus of the pipelined subtractor
interface pipelined_ks_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf, zero);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, ovf, zero);
endinterface

// File: rtl/kgp_prefix_level.sv
// kgp_prefix_level: one combinational Kogge-Stone level combining each bit with the bit DIST below it
module kgp_prefix_level
  import kgp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  kgp_t [WIDTH-1:0] i_kgp,
  output kgp_t [WIDTH-1:0] o_kgp
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign o_kgp[i] = i_kgp[i];
    end else begin : g_op
      assign o_kgp[i] = prefix_op(i_kgp[i], i_kgp[i-DIST]);
    end
  end
endmodule

// File: rtl/pipelined_ks_subtractor.sv
// pipelined_ks_subtractor: 3-stage Kogge-Stone a - b - bin with valid/ready backpressure
module pipelined_ks_subtractor
  import kgp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPLIT = 2
) (
  input logic clk,
  input logic rst_n,
  pipelined_ks_subtractor_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  logic                   w_adv;
  kgp_t [WIDTH-1:0]       w_enc;
  kgp_t [WIDTH-1:0]       w_lvl [LEVELS+1];
  kgp_t [WIDTH-1:0]       w_fin;
  logic [WIDTH-1:0]       w_p1;
  logic [WIDTH-1:0]       w_c;
  logic [WIDTH-1:0]       w_diff;
  logic                   r1_valid, r1_cin, r1_amsb, r1_bmsb;
  kgp_t [WIDTH-1:0]       r1_kgp;
  logic                   r2_valid, r2_cin, r2_amsb, r2_bmsb;
  kgp_t [WIDTH-1:0]       r2_kgp;
  logic [WIDTH-1:0]       r2_p;
  logic                   r_out_valid, r_bout, r_ovf, r_zero;
  logic [WIDTH-1:0]       r_diff;
  assign w_adv        = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  // carry-in ~bin is a generate at position -1, folded into bit 0
  always_comb begin
    w_enc = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_enc[k].g = bus.a[k] & ~bus.b[k];
      w_enc[k].p = bus.a[k] ^ ~bus.b[k];
    end
    w_enc[0].g = w_enc[0].g | (w_enc[0].p & ~bus.bin);
  end
  assign w_lvl[0] = r1_kgp;
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    kgp_t [WIDTH-1:0] w_in;
    if (l == SPLIT + 1) begin : g_from_reg
      assign w_in = r2_kgp;
    end else begin : g_chain
      assign w_in = w_lvl[l-1];
    end
    kgp_prefix_level #(.WIDTH(WIDTH), .DIST(1 << (l - 1))) u_lvl (
      .i_kgp(w_in),
      .o_kgp(w_lvl[l])
    );
  end
  if (SPLIT == LEVELS) begin : g_fin_reg
    assign w_fin = r2_kgp;
  end else begin : g_fin_lvl
    assign w_fin = w_lvl[LEVELS];
  end
  always_comb begin
    w_p1   = '0;
    w_c    = '0;
    w_c[0] = r2_cin;
    for (int k = 0; k < WIDTH; k++) w_p1[k] = r1_kgp[k].p;
    for (int k = 1; k < WIDTH; k++) w_c[k] = w_fin[k-1].g;
  end
  assign w_diff = r2_p ^ w_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_cin      <= 1'b0;
      r1_amsb     <= 1'b0;
      r1_bmsb     <= 1'b0;
      r1_kgp      <= '0;
      r2_valid    <= 1'b0;
      r2_cin      <= 1'b0;
      r2_amsb     <= 1'b0;
      r2_bmsb     <= 1'b0;
      r2_kgp      <= '0;
      r2_p        <= '0;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r1_valid    <= bus.in_valid;
      r1_cin      <= ~bus.bin;
      r1_amsb     <= bus.a[WIDTH-1];
      r1_bmsb     <= bus.b[WIDTH-1];
      r1_kgp      <= w_enc;
      r2_valid    <= r1_valid;
      r2_cin      <= r1_cin;
      r2_amsb     <= r1_amsb;
      r2_bmsb     <= r1_bmsb;
      r2_kgp      <= w_lvl[SPLIT];
      r2_p        <= w_p1;
      r_out_valid <= r2_valid;
      r_diff      <= w_diff;
      r_bout      <= ~w_fin[WIDTH-1].g;
      r_ovf       <= (r2_amsb != r2_bmsb) && (w_diff[WIDTH-1] != r2_amsb);
      r_zero      <= (w_diff == '0);
    end
  end
endmodule

// File: tb/tb_pipelined_ks_subtractor.sv
// tb_pipelined_ks_subtractor: directed and randomized self-checking bench for the pipelined subtractor
module tb_pipelined_ks_subtractor;
  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipelined_ks_subtractor_if #(.WIDTH(16)) bus ();
  pipelined_ks_subtractor #(.WIDTH(16), .SPLIT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  res_t        q[$];
  res_t        pend;
  int          ncmp = 0;
  int          nfail = 0;
  logic        acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_diff;
  logic [2:0]  prev_flags;
  logic [15:0] ta [8];
  logic [15:0] tb [8];
  logic        tbin [8];
  res_t        te [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] s;
    res_t r;
    s    = {1'b0, a} + {1'b0, ~b} + {16'b0, ~bin};
    r.d  = s[15:0];
    r.bo = ~s[16];
    r.ov = (a[15] != b[15]) && (s[15] != a[15]);
    r.z  = (s[15:0] == 16'h0);
    return r;
  endfunction

  // one clock: observe handshakes at negedge, then return 1 time unit after the rising edge
  task automatic cycle();
    res_t r;
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    if (stall_prev) begin
      chk("hold_diff", bus.diff, prev_diff);
      chk("hold_flags", {bus.bout, bus.ovf, bus.zero}, prev_flags);
    end
    if (bus.out_valid & ~bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
    stall_prev = bus.out_valid & ~bus.out_ready;
    prev_diff  = bus.diff;
    prev_flags = {bus.bout, bus.ovf, bus.zero};
    if (bus.out_valid & bus.out_ready) begin
      chk("result_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("diff", bus.diff, r.d);
        chk("bout", bus.bout, r.bo);
        chk("ovf", bus.ovf, r.ov);
        chk("zero", bus.zero, r.z);
      end
    end
    if (acc) q.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin, input res_t e);
    int n;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    pend = e;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 20);
    chk("accept", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic latency();
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency", lat, 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int k, c, n_acc;
    logic [15:0] ra, rb;
    logic rbin;
    ta   = '{16'h0010, 16'h0020, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h1000, 16'hABCD, 16'h8000};
    tb   = '{16'h0001, 16'h0020, 16'h0002, 16'hFFFF, 16'h0001, 16'h0FFF, 16'h0000, 16'h7FFF};
    tbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    te   = '{{16'h000F, 3'b000}, {16'h0000, 3'b001}, {16'hFFFF, 3'b100}, {16'h8000, 3'b110},
             {16'hFFFD, 3'b000}, {16'h0000, 3'b001}, {16'hABCD, 3'b000}, {16'h0001, 3'b010}};
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_flags", {bus.bout, bus.ovf, bus.zero}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    // basic subtraction and latency
    send(16'h0005, 16'h0003, 1'b0, {16'h0002, 3'b000});
    latency();
    drain();
    // borrow chain and borrow-in
    send(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b100});
    send(16'h0000, 16'h0001, 1'b1, {16'hFFFE, 3'b100});
    drain();
    // overflow, equal operands, zero subtrahend
    send(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b010});
    send(16'h1234, 16'h1234, 1'b0, {16'h0000, 3'b001});
    send(16'h1234, 16'h1234, 1'b1, {16'hFFFF, 3'b100});
    send(16'h5A5A, 16'h0000, 1'b0, {16'h5A5A, 3'b000});
    drain();
    // 8-beat stream with a 3-cycle output stall
    k = 0;
    c = 0;
    while ((k < 8 || q.size() > 0) && c < 80) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      if (k < 8) begin
        bus.a = ta[k];
        bus.b = tb[k];
        bus.bin = tbin[k];
        pend = te[k];
        bus.in_valid = 1'b1;
      end else bus.in_valid = 1'b0;
      cycle();
      if (acc) k++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_accepted", k, 8);
    chk("stream_delivered", q.size(), 0);
    // reset with three beats in flight
    send(16'h0111, 16'h0011, 1'b0, {16'h0100, 3'b000});
    send(16'h0222, 16'h0022, 1'b0, {16'h0200, 3'b000});
    send(16'h0333, 16'h0033, 1'b0, {16'h0300, 3'b000});
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_diff", bus.diff, 0);
    chk("midrst_flags", {bus.bout, bus.ovf, bus.zero}, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    q.delete();
    stall_prev = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) begin
      cycle();
      chk("post_rst_no_stale", bus.out_valid, 0);
    end
    send(16'h0F0F, 16'h00FF, 1'b0, {16'h0E10, 3'b000});
    latency();
    drain();
    // random traffic against the arithmetic model
    n_acc = 0;
    c = 0;
    acc = 1'b0;
    while (n_acc < 10000 && c < 60000) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        ra = 16'($urandom);
        rb = 16'($urandom);
        rbin = 1'($urandom);
        bus.a = ra;
        bus.b = rb;
        bus.bin = rbin;
        pend = model(ra, rb, rbin);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (acc) n_acc++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("random_beats", n_acc, 10000);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
